parking_lot_gate: RTL and testbench
===================================

Name: parking_lot_gate

Overview:
- Parametrised successor to the single-gate parking counter.
- Decodes a two-beam gate (sensors a, b, active-low "blocked") into entry/exit events with abort and error recovery.
- Keeps a capacity-bounded BCD occupancy count and drives the board's 3-digit multiplexed seven-segment display.
- Adds synchronisers, debounce, full/empty flags, event pulses and reject on overflow/underflow.

Parameters:
- CAPACITY, 999, maximum occupancy; legal range 1..999.
- DEB_CYCLES, 16, consecutive stable synchronised samples required before a debounced level changes; minimum 1.
- REFRESH_DIV, 50000, clock cycles per display digit slot; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a  in  1  outer beam sensor, 0 = blocked, asynchronous
- b  in  1  inner beam sensor, 0 = blocked, asynchronous
- sseg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- en  out  3  digit enables, one-hot active-low; bit0 = units, bit1 = tens, bit2 = hundreds
- count  out  10  occupancy, binary
- full  out  1  count == CAPACITY
- empty  out  1  count == 0
- car_in  out  1  one-cycle pulse on a counted entry
- car_out  out  1  one-cycle pulse on a counted exit
- reject  out  1  one-cycle pulse on entry-when-full or exit-when-empty

Behaviour:
- Reset values: count = 0, BCD digits = 0, empty = 1, full = 0, car_in/car_out/reject = 0, FSM = IDLE, debounced a/b = 1, sync flops = 1, scan slot = units, en = 3'b110, sseg = 8'hC0, refresh counter = 0. Reset mid-sequence discards the partial event.
- Input path: two-flop synchroniser per sensor feeds the debouncer.
- Debouncer: debounced level takes the synchronised value after that value differs from it for DEB_CYCLES consecutive cycles. Any agreeing sample clears the run counter.
- FSM input: ab = debounced {a,b}; 11 = clear.
  - IDLE: 01 -> ENT1; 10 -> EXT1; 00 -> ERR.
  - ENT1: 00 -> ENT2; 11 -> IDLE (abort); 10 -> ERR.
  - ENT2: 10 -> ENT3; 01 -> ENT1; 11 -> ERR.
  - ENT3: 11 -> IDLE and entry complete; 00 -> ENT2; 01 -> ERR.
  - EXT1/EXT2/EXT3: mirror of the entry states with a and b swapped. EXT3 -> IDLE on 11 means exit complete.
  - ERR: stays until 11, then -> IDLE. No count change.
  - No change in ab = hold state.
- Event timing: on the edge where the FSM performs the completing transition, count updates and the pulse is registered. The pulse is high for exactly the following cycle.
  - Entry with count < CAPACITY: count +1, car_in.
  - Entry with count == CAPACITY: count held, reject.
  - Exit with count > 0: count −1, car_out.
  - Exit with count == 0: count held, reject.
- Pulse exclusivity: car_in, car_out and reject are never simultaneously high.
- Counters: binary count and three BCD digits update together. BCD carries/borrows across digits (e.g. 099 -> 100, 100 -> 099). full/empty are combinational from count.
- Display scan: slot advances units -> tens -> hundreds -> units each time the refresh counter wraps (REFRESH_DIV − 1 -> 0). sseg and en are registered and always change on the same edge.
  - Digit codes (dp off): 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90.
  - Leading zeros are displayed.
- Sensor-to-count latency: 2 sync cycles + DEB_CYCLES + 1 FSM cycle after the final 11 level appears.

Test Plan (CAPACITY = 3, DEB_CYCLES = 2, REFRESH_DIV = 4):
- Reset, then hold a = b = 1 for 50 cycles -> count = 0, empty = 1, no pulses; en cycles 110 -> 101 -> 011 every 4 cycles with sseg = C0.
- Entry sequence ab = 01, 00, 10, 11, each held 10 cycles -> single car_in pulse, count = 1, units digit shows F9, empty = 0.
- Four entries -> count = 3, full = 1 after the third; fourth entry gives reject with count held at 3.
- Exit sequence 10, 00, 01, 11 from count = 3 -> car_out, count = 2. Exit at count = 0 -> reject, count stays 0.
- Aborts and backtracks:
  - 01 then 11 -> no event.
  - 01, 00, 01, 00, 10, 11 -> exactly one car_in.
  - 1-cycle glitch on a while idle -> no state change.
- Illegal 11 -> 00 jump -> ERR, no pulses. Then 11 -> IDLE and a normal entry counts.
- Assert rst while in ENT2 -> all reset values, and a subsequent completion without a fresh 01 does not count.

Source files
------------

// File: rtl/parking_lot_gate.sv
`default_nettype none
// ============================================================================
// Module   : parking_lot_gate
// Brief    : Two-beam parking gate decoder with bounded BCD occupancy count
//            and a 3-digit multiplexed seven-segment display driver.
// Revision : 1.0
// ============================================================================
module parking_lot_gate #(
    parameter int CAPACITY    = 999,
    parameter int DEB_CYCLES  = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    output logic [7:0] sseg,
    output logic [2:0] en,
    output logic [9:0] count,
    output logic       full,
    output logic       empty,
    output logic       car_in,
    output logic       car_out,
    output logic       reject
);

    localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_REF_W-1:0] c_REF_ONE  = c_REF_W'(1);
    localparam logic [9:0]         c_CAP      = 10'(CAPACITY);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_ENT1 = 3'd1;
    localparam logic [2:0] c_S_ENT2 = 3'd2;
    localparam logic [2:0] c_S_ENT3 = 3'd3;
    localparam logic [2:0] c_S_EXT1 = 3'd4;
    localparam logic [2:0] c_S_EXT2 = 3'd5;
    localparam logic [2:0] c_S_EXT3 = 3'd6;
    localparam logic [2:0] c_S_ERR  = 3'd7;

    // ------------------------------------------------------------------------
    // Sensor conditioning: bit1 = a (outer), bit0 = b (inner)
    // ------------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_ab;

    assign w_raw = {a, b};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic               r_meta;
            logic               r_sync;
            logic               r_deb;
            logic [c_DEB_W-1:0] r_run;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                    r_deb  <= 1'b1;
                    r_run  <= '0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_deb) begin
                        r_run <= '0;
                    end else if (r_run == c_DEB_LAST) begin
                        r_deb <= r_sync;
                        r_run <= '0;
                    end else begin
                        r_run <= r_run + c_DEB_ONE;
                    end
                end
            end

            assign w_ab[gi] = r_deb;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // BCD helpers and segment decode
    // ------------------------------------------------------------------------
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] w_res;
        w_res = v;
        if (v[3:0] != 4'd9) begin
            w_res[3:0] = v[3:0] + 4'd1;
        end else begin
            w_res[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                w_res[7:4] = v[7:4] + 4'd1;
            end else begin
                w_res[7:4]  = 4'd0;
                w_res[11:8] = v[11:8] + 4'd1;
            end
        end
        return w_res;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] w_res;
        w_res = v;
        if (v[3:0] != 4'd0) begin
            w_res[3:0] = v[3:0] - 4'd1;
        end else begin
            w_res[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                w_res[7:4] = v[7:4] - 4'd1;
            end else begin
                w_res[7:4]  = 4'd9;
                w_res[11:8] = v[11:8] - 4'd1;
            end
        end
        return w_res;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Gate FSM with occupancy counters and event pulses
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [9:0]  r_count;
    logic [11:0] r_bcd;
    logic        r_car_in;
    logic        r_car_out;
    logic        r_reject;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_count   <= '0;
            r_bcd     <= '0;
            r_car_in  <= 1'b0;
            r_car_out <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            r_car_in  <= 1'b0;
            r_car_out <= 1'b0;
            r_reject  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    case (w_ab)
                        2'b01:   r_state <= c_S_ENT1;
                        2'b10:   r_state <= c_S_EXT1;
                        2'b00:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                c_S_ENT1: begin
                    case (w_ab)
                        2'b00:   r_state <= c_S_ENT2;
                        2'b11:   r_state <= c_S_IDLE;
                        2'b10:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                c_S_ENT2: begin
                    case (w_ab)
                        2'b10:   r_state <= c_S_ENT3;
                        2'b01:   r_state <= c_S_ENT1;
                        2'b11:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                c_S_ENT3: begin
                    case (w_ab)
                        2'b11: begin
                            r_state <= c_S_IDLE;
                            if (r_count != c_CAP) begin
                                r_count  <= r_count + 10'd1;
                                r_bcd    <= bcd_inc(r_bcd);
                                r_car_in <= 1'b1;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                        2'b00:   r_state <= c_S_ENT2;
                        2'b01:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                c_S_EXT1: begin
                    case (w_ab)
                        2'b00:   r_state <= c_S_EXT2;
                        2'b11:   r_state <= c_S_IDLE;
                        2'b01:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                c_S_EXT2: begin
                    case (w_ab)
                        2'b01:   r_state <= c_S_EXT3;
                        2'b10:   r_state <= c_S_EXT1;
                        2'b11:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                c_S_EXT3: begin
                    case (w_ab)
                        2'b11: begin
                            r_state <= c_S_IDLE;
                            if (r_count != 10'd0) begin
                                r_count   <= r_count - 10'd1;
                                r_bcd     <= bcd_dec(r_bcd);
                                r_car_out <= 1'b1;
                            end else begin
                                r_reject  <= 1'b1;
                            end
                        end
                        2'b00:   r_state <= c_S_EXT2;
                        2'b10:   r_state <= c_S_ERR;
                        default: ;
                    endcase
                end
                default: begin
                    // Error recovery only through a fully clear gate
                    if (w_ab == 2'b11) begin
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------------
    logic [c_REF_W-1:0] r_ref;
    logic [1:0]         r_slot;
    logic [2:0]         r_en;
    logic [7:0]         r_sseg;
    logic               w_ref_wrap;
    logic [1:0]         w_slot_next;
    logic [3:0]         w_digit;

    always_comb begin
        w_ref_wrap  = (r_ref == c_REF_LAST);
        w_slot_next = r_slot;
        if (w_ref_wrap) begin
            w_slot_next = (r_slot == 2'd2) ? 2'd0 : r_slot + 2'd1;
        end
        case (w_slot_next)
            2'd1:    w_digit = r_bcd[7:4];
            2'd2:    w_digit = r_bcd[11:8];
            default: w_digit = r_bcd[3:0];
        endcase
    end

    // Segments are refreshed every cycle so a count change shows without
    // waiting for the next slot; en and sseg share the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref  <= '0;
            r_slot <= 2'd0;
            r_en   <= 3'b110;
            r_sseg <= 8'hC0;
        end else begin
            r_ref  <= w_ref_wrap ? '0 : r_ref + c_REF_ONE;
            r_slot <= w_slot_next;
            r_en   <= ~(3'b001 << w_slot_next);
            r_sseg <= seg_of(w_digit);
        end
    end

    assign sseg    = r_sseg;
    assign en      = r_en;
    assign count   = r_count;
    assign full    = (r_count == c_CAP);
    assign empty   = (r_count == 10'd0);
    assign car_in  = r_car_in;
    assign car_out = r_car_out;
    assign reject  = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_lot_gate
// Brief    : Scoreboard bench for parking_lot_gate with a path-based gate model.
// Revision : 1.0
// ============================================================================
module tb_parking_lot_gate;

    localparam int CAPACITY    = 3;
    localparam int DEB_CYCLES  = 2;
    localparam int REFRESH_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a   = 1'b1;
    logic       b   = 1'b1;
    logic [7:0] sseg;
    logic [2:0] en;
    logic [9:0] count;
    logic       full;
    logic       empty;
    logic       car_in;
    logic       car_out;
    logic       reject;

    parking_lot_gate #(
        .CAPACITY   (CAPACITY),
        .DEB_CYCLES (DEB_CYCLES),
        .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .sseg   (sseg),
        .en     (en),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .car_in (car_in),
        .car_out(car_out),
        .reject (reject)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard entries: kind 1 = car_in, 2 = car_out, 3 = reject
    typedef struct packed {
        logic [1:0] kind;
        logic [9:0] cnt;
    } ev_t;
    ev_t exp_q[$];

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model: a car is a walk along the beam path 11-01-00-10-11
    // (exit uses the mirrored path); neighbour steps move along it, anything
    // else is an error until the gate clears.
    int         m_count;
    int         m_dir;      // 0 idle, 1 entering, 2 leaving, 3 error
    int         m_pos;
    logic [1:0] m_level;

    function automatic int path_idx(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_step(input logic [1:0] ab);
        logic [1:0] v;
        int idx;
        if (ab == m_level) return;
        m_level = ab;
        if (m_dir == 3) begin
            if (ab == 2'b11) m_dir = 0;
            return;
        end
        if (m_dir == 0) begin
            m_pos = 1;
            if (ab == 2'b01)      m_dir = 1;
            else if (ab == 2'b10) m_dir = 2;
            else                  m_dir = 3;
            return;
        end
        v   = (m_dir == 2) ? {ab[0], ab[1]} : ab;
        idx = path_idx(v);
        if (idx == 0 && m_pos == 3) begin
            if (m_dir == 1 && m_count < CAPACITY) begin
                m_count++;
                exp_q.push_back('{kind: 2'd1, cnt: 10'(m_count)});
            end else if (m_dir == 2 && m_count > 0) begin
                m_count--;
                exp_q.push_back('{kind: 2'd2, cnt: 10'(m_count)});
            end else begin
                exp_q.push_back('{kind: 2'd3, cnt: 10'(m_count)});
            end
            m_dir = 0;
        end else if (idx == 0 && m_pos == 1) begin
            m_dir = 0;
        end else if (idx != 0 && (idx == m_pos + 1 || idx == m_pos - 1)) begin
            m_pos = idx;
        end else begin
            m_dir = 3;
        end
    endtask

    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: every pulse must match the oldest predicted event
    ev_t mon_e;
    always @(negedge clk) begin
        if (!rst && (car_in || car_out || reject)) begin
            check("pulse_exclusive", {29'd0, car_in, car_out, reject} & ({29'd0, car_in, car_out, reject} - 32'd1), 32'd0);
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", {30'd0, car_in ? 2'd1 : car_out ? 2'd2 : 2'd3}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {30'd0, car_in ? 2'd1 : car_out ? 2'd2 : 2'd3}, {30'd0, mon_e.kind});
                check("pulse_count", {22'd0, count}, {22'd0, mon_e.cnt});
            end
        end
    end

    task automatic check_display();
        int slot;
        int p;
        int digit;
        slot  = (cyc / REFRESH_DIV) % 3;
        p     = (slot == 0) ? 1 : (slot == 1) ? 10 : 100;
        digit = (m_count / p) % 10;
        check("en", {29'd0, en}, ~(32'd1 << slot) & 32'h7);
        check("sseg", {24'd0, sseg}, {24'd0, seg_tbl[digit]});
    endtask

    task automatic check_flags();
        check("count", {22'd0, count}, 32'(m_count));
        check("full", {31'd0, full}, {31'd0, m_count == CAPACITY});
        check("empty", {31'd0, empty}, {31'd0, m_count == 0});
    endtask

    task automatic apply(input logic [1:0] ab, input int hold);
        @(negedge clk);
        {a, b} = ab;
        model_step(ab);
        repeat (hold - 1) @(negedge clk);
        check_flags();
    endtask

    task automatic entry_seq();
        apply(2'b01, 10); apply(2'b00, 10); apply(2'b10, 10); apply(2'b11, 10);
    endtask

    task automatic exit_seq();
        apply(2'b10, 10); apply(2'b00, 10); apply(2'b01, 10); apply(2'b11, 10);
    endtask

    task automatic glitch(input bit on_a);
        @(negedge clk);
        if (on_a) a = ~a; else b = ~b;
        @(negedge clk);
        if (on_a) a = ~a; else b = ~b;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        check("rst_count", {22'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_pulses", {29'd0, car_in, car_out, reject}, 32'd0);
        check("rst_en", {29'd0, en}, 32'h6);
        check("rst_sseg", {24'd0, sseg}, 32'hC0);
        rst     = 1'b0;
        m_count = 0;
        m_dir   = 0;
        m_pos   = 0;
        m_level = 2'b11;
        exp_q.delete();
        model_step({a, b});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rab;
        int         r;

        do_reset(3);

        // Idle scan: leading zeros, full digit rotation
        repeat (50) begin
            @(negedge clk);
            check_display();
        end
        check_flags();

        // Four entries: last one hits capacity
        entry_seq();
        repeat (12) begin @(negedge clk); check_display(); end
        entry_seq();
        entry_seq();
        entry_seq();

        // Exits down past empty
        exit_seq();
        exit_seq();
        exit_seq();
        exit_seq();
        repeat (12) begin @(negedge clk); check_display(); end

        // Abort, backtracking entry, idle glitch
        apply(2'b01, 10); apply(2'b11, 10);
        apply(2'b01, 10); apply(2'b00, 10); apply(2'b01, 10);
        apply(2'b00, 10); apply(2'b10, 10); apply(2'b11, 10);
        glitch(1'b1);
        check_flags();

        // Illegal jump into error, recovery, then a normal entry
        apply(2'b00, 10); apply(2'b11, 10);
        entry_seq();

        // Reset in the middle of an entry
        apply(2'b01, 10); apply(2'b00, 10);
        do_reset(3);
        repeat (9) @(negedge clk);
        apply(2'b10, 10); apply(2'b11, 10);
        check_flags();

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                entry_seq();
            end else if (r < 6) begin
                exit_seq();
            end else if (r < 8) begin
                rab = 2'($urandom_range(0, 3));
                apply(rab, $urandom_range(8, 14));
            end else begin
                glitch(1'($urandom_range(0, 1)));
            end
            if (i % 10 == 0) check_display();
        end
        apply(2'b11, 10);
        repeat (20) @(negedge clk);
        check("queue_drain", exp_q.size(), 32'd0);
        check_flags();
        check_display();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
